a23_sw_debounce: RTL and testbench
==================================

# a23_sw_debounce

Input-conditioning stage between the board switch pins (sw1..sw4) and the a23_mini_sys GPIO logic. It synchronises each asynchronous switch into `clk_i`, then filters contact bounce with a per-channel stability counter. It outputs clean levels and single-cycle edge pulses, plus a valid/ready event stream that a GPIO or interrupt register can consume.

## Interface
- N_SW, 4, number of switch channels (1..8)
- DEBOUNCE_CYCLES, 16, consecutive agreeing samples needed before the debounced level changes (≥2)
- CH_W, $clog2(N_SW) min 1, derived localparam, event channel-index width
- clk_i  in  1  system clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- sw_i  in  N_SW  raw switch levels, asynchronous
- sw_o  out  N_SW  debounced levels
- rise_o  out  N_SW  one-cycle pulse when sw_o[i] goes 0→1
- fall_o  out  N_SW  one-cycle pulse when sw_o[i] goes 1→0
- evt_valid_o  out  1  event slot holds an event
- evt_ch_o  out  CH_W  channel of the held event
- evt_level_o  out  1  new debounced level of the held event
- evt_ready_i  in  1  consumer accepts the event when valid & ready
- overflow_o  out  1  sticky flag: a channel changed again while its event was still unaccepted

## Operation
- Per channel, sw_i passes through a 2-flop synchroniser (s1, s2). cnt is CNT_W = $clog2(DEBOUNCE_CYCLES+1) bits. stable drives sw_o.
- If s2 == stable: cnt ← 0.
- If s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable ← s2, cnt ← 0, and the channel "flips".
- If s2 != stable otherwise: cnt ← cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES samples resets cnt and produces no flip.
- A flip pulses rise_o or fall_o for one cycle and sets pending[i].
- If pending[i] is already set when channel i flips: overflow_o ← 1 (sticky), and pending[i] stays at 1. Only one event is reported; its level is the stable value at load time.
- Event slot loading:
  - The slot loads when it is empty, or in the same cycle it is accepted.
  - It takes the lowest-index set pending bit, latches the channel index and that channel's current stable level, and clears that pending bit.
  - A flip arriving in the same cycle as the load of that channel sets pending again; set wins over clear.
- While evt_valid_o=1, evt_ch_o and evt_level_o hold until accepted.
- Reset clears s1, s2, cnt, stable, pending, the slot, and overflow_o. All outputs are 0 the cycle after rst_i is sampled high. This holds mid-debounce and mid-handshake, and any in-flight event is dropped.
- A switch held high through reset debounces to 1 after release and produces a rise event.

## Timing
- Let edge 1 be the first rising clk_i edge that samples a new sw_i level, with the level held steady afterwards.
- sw_o and rise_o/fall_o update on edge DEBOUNCE_CYCLES+2. That is edge 18 with the default.
- pending is set on the same edge as the flip. evt_valid_o rises one edge later if the slot is free.
- Back-to-back acceptance (evt_ready_i held at 1) drains one event per cycle.
- Simultaneous flips on several channels are presented in ascending channel order on consecutive cycles.
- evt_ready_i has no combinational path to any output. The slot is fully registered.

## Structure
- a23_sw_debounce_pkg holds the event struct typedef {ch, level} and the default-parameter constants.
- Sub-module a23_sw_debounce_chan contains the synchroniser, counter, stable register and flip pulse. It is instantiated N_SW times.
- The top level holds the pending vector, the priority picker, the event slot, and overflow.

## Test plan
- Clean step: sw_i[0] 0→1 held → sw_o[0]=1 and rise_o[0] pulses exactly on edge 18. Then evt_ch=0, level=1 is valid on edge 19.
- Bounce: sw_i[1] toggles every 5 cycles for 100 cycles, then settles at 1 → no flip during the toggling, exactly one rise after settling, one event.
- Simultaneous: sw_i 0000→1111 in one cycle with evt_ready_i=1 → events ch 0,1,2,3 on consecutive cycles, all level=1, overflow_o=0.
- Backpressure/overflow: evt_ready_i=0, ch2 rises then falls (each held ≥20 cycles) → overflow_o=1, and one event is reported for ch2. With ready raised, that event carries ch=2, level=0.
- Reset mid-operation: assert rst_i at cnt=10 with an event pending → all outputs 0 next cycle. With sw_i[3]=1 held, a rise on ch3 occurs 18 edges after reset release.
- N_SW=1, DEBOUNCE_CYCLES=2 build: a step produces a flip on edge 4, and CH_W=1 with evt_ch_o=0.

Source files
------------

// File: rtl/a23_sw_debounce_pkg.sv
// Shared types and defaults for the switch debouncer: event record, channel limits
// and the lowest-set-bit picker used by the event slot.
package a23_sw_debounce_pkg;

  localparam int unsigned DefNSw            = 4;
  localparam int unsigned DefDebounceCycles = 16;
  localparam int unsigned MaxSw             = 8;
  localparam int unsigned MaxChW            = 3;

  typedef struct packed {
    logic [MaxChW-1:0] ch;
    logic              level;
  } evt_t;

  // Returns the index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [MaxChW-1:0] lowest_set(input logic [MaxSw-1:0] vec);
    logic [MaxChW-1:0] idx;
    idx = '0;
    for (int i = MaxSw - 1; i >= 0; i--) begin
      if (vec[i]) idx = MaxChW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/a23_sw_debounce_chan.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced level
// and registered rise/fall pulses. flip_o is the combinational flip for this edge.
module a23_sw_debounce_chan
  import a23_sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o,
  output logic flip_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic w_differ;
  logic w_flip;

  assign w_differ = (r_s2 != r_stable);
  assign w_flip   = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1   <= sw_i;
      r_s2   <= r_s1;
      r_rise <= w_flip & r_s2;
      r_fall <= w_flip & ~r_s2;
      if (w_flip) r_stable <= r_s2;
      // Any agreeing sample restarts the count, so short glitches never accumulate.
      if (!w_differ || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sw_o   = r_stable;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign flip_o = w_flip;

endmodule

// File: rtl/a23_sw_debounce.sv
// Switch debouncer top: N_SW debounce channels feeding a pending vector, a
// lowest-index picker and a single registered valid/ready event slot.
module a23_sw_debounce
  import a23_sw_debounce_pkg::*;
#(
  parameter int unsigned N_SW            = DefNSw,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  localparam int unsigned CH_W           = (N_SW > 1) ? $clog2(N_SW) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_SW-1:0] sw_i,
  output logic [N_SW-1:0] sw_o,
  output logic [N_SW-1:0] rise_o,
  output logic [N_SW-1:0] fall_o,
  output logic            evt_valid_o,
  output logic [CH_W-1:0] evt_ch_o,
  output logic            evt_level_o,
  input  logic            evt_ready_i,
  output logic            overflow_o
);

  logic [N_SW-1:0] w_stable;
  logic [N_SW-1:0] w_flip;

  for (genvar g = 0; g < N_SW; g++) begin : g_chan
    a23_sw_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .sw_i  (sw_i[g]),
      .sw_o  (w_stable[g]),
      .rise_o(rise_o[g]),
      .fall_o(fall_o[g]),
      .flip_o(w_flip[g])
    );
  end

  logic [N_SW-1:0]  r_pending;
  logic             r_valid;
  logic [CH_W-1:0]  r_ch;
  logic             r_level;
  logic             r_ovf;

  logic [MaxSw-1:0] w_pend_ext;
  logic [MaxSw-1:0] w_stable_ext;
  evt_t             w_cand;
  logic             w_load;
  logic [N_SW-1:0]  w_clr;
  logic [N_SW-1:0]  w_pend_d;
  logic             w_ovf_hit;

  always_comb begin
    w_pend_ext               = '0;
    w_pend_ext[N_SW-1:0]     = r_pending;
    w_stable_ext             = '0;
    w_stable_ext[N_SW-1:0]   = w_stable;
    w_cand.ch                = lowest_set(w_pend_ext);
    w_cand.level             = w_stable_ext[w_cand.ch];
    // Slot refills when empty or in the very cycle its event is taken.
    w_load                   = (|r_pending) && (!r_valid || evt_ready_i);
    w_clr                    = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      w_clr[i] = w_load && (w_cand.ch == MaxChW'(i));
    end
    // A new flip wins over the clear from a same-cycle load.
    w_pend_d                 = (r_pending & ~w_clr) | w_flip;
    // A flip on a bit being loaded this cycle is captured, so it is not an overflow.
    w_ovf_hit                = |(w_flip & r_pending & ~w_clr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_ch      <= '0;
      r_level   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= w_pend_d;
      if (w_ovf_hit) r_ovf <= 1'b1;
      if (w_load) begin
        r_valid <= 1'b1;
        r_ch    <= w_cand.ch[CH_W-1:0];
        r_level <= w_cand.level;
      end else if (evt_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sw_o        = w_stable;
  assign evt_valid_o = r_valid;
  assign evt_ch_o    = r_ch;
  assign evt_level_o = r_level;
  assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_a23_sw_debounce.sv
// Directed bench for the switch debouncer; expected events go into a queue that a
// separate monitor checks at every valid/ready handshake.
module tb_a23_sw_debounce;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [3:0] sw;
  logic [3:0] sw_o, rise_o, fall_o;
  logic       evt_valid, evt_level, evt_ready, overflow;
  logic [1:0] evt_ch;

  logic       sw1;
  logic       sw_o1, rise1, fall1, valid1, level1, ovf1;
  logic       ch1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int ch;
    int level;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  a23_sw_debounce u_dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .sw_i       (sw),
    .sw_o       (sw_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .evt_valid_o(evt_valid),
    .evt_ch_o   (evt_ch),
    .evt_level_o(evt_level),
    .evt_ready_i(evt_ready),
    .overflow_o (overflow)
  );

  a23_sw_debounce #(
    .N_SW           (1),
    .DEBOUNCE_CYCLES(2)
  ) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .sw_i       (sw1),
    .sw_o       (sw_o1),
    .rise_o     (rise1),
    .fall_o     (fall1),
    .evt_valid_o(valid1),
    .evt_ch_o   (ch1),
    .evt_level_o(level1),
    .evt_ready_i(1'b1),
    .overflow_o (ovf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int ch, input int level);
    exp_t e;
    e.ch    = ch;
    e.level = level;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted event must match the head of the queue.
  always @(negedge clk) begin
    if (!rst_i && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL evt_unexpected actual=ch%0d/lvl%0d expected=none", evt_ch, evt_level);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("evt_ch", 32'(evt_ch), 32'(e.ch));
        chk("evt_level", 32'(evt_level), 32'(e.level));
      end
    end
  end

  initial begin
    int n_pulse;
    int n_rise;
    int n_fall;
    rst_i     = 1'b1;
    sw        = 4'b0000;
    sw1       = 1'b0;
    evt_ready = 1'b1;
    tick(2);
    chk("reset_sw_o", 32'(sw_o), 0);
    chk("reset_valid", 32'(evt_valid), 0);
    chk("reset_ovf", 32'(overflow), 0);
    rst_i = 1'b0;
    tick(2);

    // Minimal build: N_SW=1, DEBOUNCE_CYCLES=2 flips on edge 4.
    sw1 = 1'b1;
    tick(3);
    chk("small_e3_sw_o", 32'(sw_o1), 0);
    tick(1);
    chk("small_e4_sw_o", 32'(sw_o1), 1);
    chk("small_e4_rise", 32'(rise1), 1);
    tick(1);
    chk("small_e5_valid", 32'(valid1), 1);
    chk("small_e5_ch", 32'(ch1), 0);
    chk("small_e5_level", 32'(level1), 1);
    tick(3);

    // Clean step on ch0.
    push(0, 1);
    sw[0] = 1'b1;
    tick(17);
    chk("step_e17_sw_o", 32'(sw_o[0]), 0);
    chk("step_e17_rise", 32'(rise_o[0]), 0);
    tick(1);
    chk("step_e18_sw_o", 32'(sw_o[0]), 1);
    chk("step_e18_rise", 32'(rise_o[0]), 1);
    chk("step_e18_valid", 32'(evt_valid), 0);
    tick(1);
    chk("step_e19_rise", 32'(rise_o[0]), 0);
    chk("step_e19_valid", 32'(evt_valid), 1);
    chk("step_e19_ch", 32'(evt_ch), 0);
    tick(3);

    // Bounce on ch1: 5-cycle runs never reach the threshold.
    n_pulse = 0;
    for (int i = 0; i < 20; i++) begin
      sw[1] = ~sw[1];
      for (int k = 0; k < 5; k++) begin
        tick(1);
        if (rise_o[1] || fall_o[1]) n_pulse++;
      end
    end
    chk("bounce_no_flip", 32'(n_pulse), 0);
    push(1, 1);
    sw[1] = 1'b1;
    n_rise = 0;
    n_fall = 0;
    for (int k = 0; k < 25; k++) begin
      tick(1);
      if (rise_o[1]) n_rise++;
      if (fall_o[1]) n_fall++;
    end
    chk("bounce_rises", 32'(n_rise), 1);
    chk("bounce_falls", 32'(n_fall), 0);

    // Back to all-low: two simultaneous falls.
    push(0, 0);
    push(1, 0);
    sw = 4'b0000;
    tick(24);
    chk("low_sw_o", 32'(sw_o), 0);

    // Simultaneous rise on all channels drains in ascending order.
    for (int i = 0; i < 4; i++) push(i, 1);
    sw = 4'b1111;
    tick(18);
    chk("sim_e18_rise", 32'(rise_o), 32'hf);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("sim_valid", 32'(evt_valid), 1);
      chk("sim_ch_order", 32'(evt_ch), 32'(i));
    end
    tick(1);
    chk("sim_drained", 32'(evt_valid), 0);
    chk("sim_ovf", 32'(overflow), 0);

    // Backpressure: slot held by ch0, ch2 changes repeatedly behind it.
    evt_ready = 1'b0;
    push(0, 0);
    push(2, 0);
    sw[0] = 1'b0;
    tick(22);
    sw[2] = 1'b0;
    tick(22);
    chk("bp_ovf_before", 32'(overflow), 0);
    sw[2] = 1'b1;
    tick(22);
    sw[2] = 1'b0;
    tick(22);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_hold_valid", 32'(evt_valid), 1);
    chk("bp_hold_ch", 32'(evt_ch), 0);
    evt_ready = 1'b1;
    tick(4);
    chk("bp_drained", 32'(evt_valid), 0);

    // Reset mid-handshake and mid-debounce.
    evt_ready = 1'b0;
    sw[1] = 1'b0;
    tick(20);
    chk("rst_pre_valid", 32'(evt_valid), 1);
    sw[0] = 1'b1;
    tick(12);
    rst_i = 1'b1;
    tick(1);
    chk("rst_sw_o", 32'(sw_o), 0);
    chk("rst_rise", 32'(rise_o), 0);
    chk("rst_fall", 32'(fall_o), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_ch_level", 32'({evt_ch, evt_level}), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_i     = 1'b0;
    evt_ready = 1'b1;
    push(0, 1);
    push(3, 1);
    tick(17);
    chk("post_rst_e17_rise", 32'(rise_o), 0);
    tick(1);
    chk("post_rst_e18_rise", 32'(rise_o), 32'h9);
    chk("post_rst_e18_sw_o", 32'(sw_o), 32'h9);
    tick(5);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
